// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline register.
package pipe_pkg;

    localparam int PIPE_CNT_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } pipe_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with a synchronous clear; sticks at all-ones.
module pipe_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {WIDTH{1'b0}};
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule : pipe_sat_counter

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with registered in_ready/out_valid and flush.
// Optional stall/flush statistics when PIPE_SKID_REG_STATS_EN is defined.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 105,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_REG_STATS_EN
    ,
    output logic [PIPE_CNT_W-1:0] stall_cnt,
    output logic [PIPE_CNT_W-1:0] flush_cnt
`endif
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    // Next state and payload loads; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end else begin
                    state_d = EMPTY;
                end
            end
            BUSY: begin
                if (in_valid && out_ready) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end else if (in_valid) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end else begin
                    state_d = BUSY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = {DATA_W{1'b0}};
                skid_d = {DATA_W{1'b0}};
            end else begin
                main_d = main_q;
                skid_d = skid_q;
            end
        end else begin
            state_d = state_d;
        end

        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // State, payload and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= {DATA_W{1'b0}};
            skid_q      <= {DATA_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef PIPE_SKID_REG_STATS_EN
    logic stall_inc_s;
    logic flush_inc_s;

    assign stall_inc_s = out_valid_q && !out_ready;
    assign flush_inc_s = flush && (state_q != EMPTY);

    pipe_sat_counter #(.WIDTH(PIPE_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .clear (1'b0),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.WIDTH(PIPE_CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc_s),
        .clear (1'b0),
        .count (flush_cnt)
    );
`endif

endmodule : pipe_skid_reg
